spi_master_xfer: RTL and testbench

//  SPI master driving the MCU SPI slave interface: sends 8-bit config bytes on MOSI and reads 16-bit angle words on MISO.

---
 rtl/spi_master_pkg.sv | 25 ++
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_master_xfer.sv | 155 +++++++++++++++
 tb/tb_spi_master_xfer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared states, transfer direction and SPI mode constants for spi_master_xfer.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    typedef enum logic {
        SPI_WR = 1'b0,
        SPI_RD = 1'b1
    } rw_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    function automatic logic is_active(input state_t s);
        return s == SETUP || s == SHIFT || s == HOLD;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period divider producing tick, sclk rise/fall strobes and the sclk level.
module spi_clk_div #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    input  logic shift_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = en && cnt_q == CW'(DIV - 1);
    assign rise = tick && shift_en && !sclk;
    assign fall = tick && shift_en && sclk;

    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick && shift_en)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_master_xfer.sv
// spi_master_xfer: mode-0 SPI master, TX_BITS writes / RX_BITS reads, MSB first.
// Define SPI_MASTER_RDY_WAIT_EN to hold reads in WAIT_RDY until data_ready_in is seen.
import spi_master_pkg::*;

module spi_master_xfer #(
    parameter int CLK_DIV = 8,
    parameter int TX_BITS = 8,
    parameter int RX_BITS = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start_in,
    input  logic               rw_in,
    input  logic [TX_BITS-1:0] tx_data_in,
    input  logic               MISO_in,
    input  logic               data_ready_in,
    output logic               sclk_out,
    output logic               SS_out,
    output logic               MOSI_out,
    output logic [RX_BITS-1:0] rx_data_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int CW = $clog2(RX_BITS + 1);

    state_t             state_q, state_d;
    rw_t                rw_q, rw_d;
    logic [TX_BITS-1:0] tx_q, tx_d;
    logic [RX_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [RX_BITS-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic               mosi_q, mosi_d;
    logic [1:0]         miso_ff;
    logic               miso_s;
    logic               div_en, tick, rise, fall, sclk;
    logic [CW-1:0]      n_bits;

    always_ff @(posedge clk) begin
        if (!n_rst)
            miso_ff <= '0;
        else
            miso_ff <= {miso_ff[0], MISO_in};
    end
    assign miso_s = miso_ff[1];

`ifdef SPI_MASTER_RDY_WAIT_EN
    logic [1:0] rdy_ff;
    logic       rdy_s;
    always_ff @(posedge clk) begin
        if (!n_rst)
            rdy_ff <= '0;
        else
            rdy_ff <= {rdy_ff[0], data_ready_in};
    end
    assign rdy_s = rdy_ff[1];
`else
    logic unused_rdy;
    assign unused_rdy = data_ready_in;
`endif

    assign div_en = is_active(state_q);

    spi_clk_div #(.DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (div_en),
        .clr      (!div_en),
        .shift_en (state_q == SHIFT),
        .tick     (tick),
        .rise     (rise),
        .fall     (fall),
        .sclk     (sclk)
    );

    assign n_bits = rw_q == SPI_RD ? CW'(RX_BITS) : CW'(TX_BITS);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            rw_q      <= SPI_WR;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = mosi_q;
        case (state_q)
            IDLE: if (start_in) begin
                rw_d      = rw_t'(rw_in);
                tx_d      = tx_data_in;
                rx_sh_d   = '0;
                bit_cnt_d = '0;
                mosi_d    = !rw_in && tx_data_in[TX_BITS-1];
`ifdef SPI_MASTER_RDY_WAIT_EN
                state_d   = rw_in ? WAIT_RDY : SETUP;
`else
                state_d   = SETUP;
`endif
            end
`ifdef SPI_MASTER_RDY_WAIT_EN
            WAIT_RDY: if (rdy_s) state_d = SETUP;
`endif
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: begin
                if (rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (rw_q == SPI_RD)
                        rx_sh_d = {rx_sh_q[RX_BITS-2:0], miso_s};
                end
                if (fall) begin
                    tx_d   = tx_q << 1;
                    mosi_d = rw_q == SPI_WR && tx_q[TX_BITS-2];
                    if (bit_cnt_q == n_bits)
                        state_d = HOLD;
                end
            end
            // rx_data_out is loaded on entry to DONE so it is valid alongside done_out
            HOLD: if (tick) begin
                state_d = DONE;
                mosi_d  = 1'b0;
                if (rw_q == SPI_RD)
                    rx_data_d = rx_sh_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sclk_out    = sclk ^ CPOL;
    assign SS_out      = !is_active(state_q);
    assign MOSI_out    = mosi_q;
    assign rx_data_out = rx_data_q;
    assign busy_out    = state_q != IDLE;
    assign done_out    = state_q == DONE;

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb_spi_master_xfer: directed bench with a mode-0 slave model for spi_master_xfer.
module tb_spi_master_xfer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start_in = 1'b0;
    logic        rw_in = 1'b0;
    logic [7:0]  tx_data_in = '0;
    logic        MISO_in;
    logic        data_ready_in = 1'b0;
    logic        sclk_out, SS_out, MOSI_out, busy_out, done_out;
    logic [15:0] rx_data_out;

    int passed = 0;
    int total = 0;

    logic [15:0] slave_word = '0;
    logic [15:0] slave_sh = '0;
    logic [15:0] cap = '0;
    logic [7:0]  last_byte = '0;
    int          rises = 0;

    spi_master_xfer #(.CLK_DIV(8), .TX_BITS(8), .RX_BITS(16)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start_in      (start_in),
        .rw_in         (rw_in),
        .tx_data_in    (tx_data_in),
        .MISO_in       (MISO_in),
        .data_ready_in (data_ready_in),
        .sclk_out      (sclk_out),
        .SS_out        (SS_out),
        .MOSI_out      (MOSI_out),
        .rx_data_out   (rx_data_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk = ~clk;

    // Mode-0 slave: MSB ready at SS fall, shifts on sclk fall, captures MOSI on sclk rise
    assign MISO_in = slave_sh[15];
    always @(negedge SS_out) begin
        slave_sh = slave_word;
        cap = '0;
        rises = 0;
    end
    always @(posedge SS_out) last_byte = cap[7:0];
    always @(posedge sclk_out) if (!SS_out) begin
        cap = {cap[14:0], MOSI_out};
        rises++;
    end
    always @(negedge sclk_out) if (!SS_out) slave_sh = slave_sh << 1;

    task automatic start_xfer(input logic rw, input logic [7:0] d);
        @(negedge clk);
        start_in = 1'b1;
        rw_in = rw;
        tx_data_in = d;
        @(posedge clk);
        #1 start_in = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n, output int ss_hi);
        n = -1;
        ss_hi = 0;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            if (done_out) begin
                n = i;
                break;
            end
            if (SS_out) ss_hi++;
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (sclk_out !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk_out); else passed++;
        total++; if (SS_out !== 1'b1) $display("FAIL reset_ss got %b want 1", SS_out); else passed++;
        total++; if (MOSI_out !== 1'b0) $display("FAIL reset_mosi got %b want 0", MOSI_out); else passed++;
        total++; if (rx_data_out !== 16'h0) $display("FAIL reset_rx got %h want 0000", rx_data_out); else passed++;
        total++; if (busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_out); else passed++;
        total++; if (done_out !== 1'b0) $display("FAIL reset_done got %b want 0", done_out); else passed++;
        @(negedge clk) n_rst = 1'b1;
    endtask

    task automatic test_write;
        int n, ss_hi;
        start_xfer(1'b0, 8'hA5);
        total++; if (busy_out !== 1'b1) $display("FAIL wr_busy got %b want 1", busy_out); else passed++;
        total++; if (SS_out !== 1'b0) $display("FAIL wr_ss_low got %b want 0", SS_out); else passed++;
        total++; if (MOSI_out !== 1'b1) $display("FAIL wr_mosi_msb got %b want 1", MOSI_out); else passed++;
        wait_done(400, n, ss_hi);
        // start cycle counts as cycle 0; first edge after accept ends cycle 0
        total++; if (n + 1 !== 145) $display("FAIL wr_latency got %0d want 145", n + 1); else passed++;
        total++; if (last_byte !== 8'hA5) $display("FAIL wr_byte got %h want a5", last_byte); else passed++;
        total++; if (rises !== 8) $display("FAIL wr_rises got %0d want 8", rises); else passed++;
        total++; if (SS_out !== 1'b1 || MOSI_out !== 1'b0) $display("FAIL wr_done_lines got ss=%b mosi=%b want 1 0", SS_out, MOSI_out); else passed++;
        @(posedge clk);
        #1;
        total++; if (done_out !== 1'b0 || busy_out !== 1'b0) $display("FAIL wr_pulse got done=%b busy=%b want 0 0", done_out, busy_out); else passed++;
    endtask

    task automatic test_read;
        int n, ss_hi;
        slave_word = 16'h1234;
        start_xfer(1'b1, 8'h00);
        wait_done(700, n, ss_hi);
        total++; if (n + 1 !== 273) $display("FAIL rd_latency got %0d want 273", n + 1); else passed++;
        total++; if (rx_data_out !== 16'h1234) $display("FAIL rd_word got %h want 1234", rx_data_out); else passed++;
        total++; if (rises !== 16) $display("FAIL rd_rises got %0d want 16", rises); else passed++;
        total++; if (ss_hi !== 0) $display("FAIL rd_ss_low got %0d high cycles want 0", ss_hi); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy;
        int dn = 0;
        logic [15:0] rx_at_done = '0;
        slave_word = 16'hBEEF;
        start_xfer(1'b1, 8'h00);
        repeat (40) @(posedge clk);
        start_xfer(1'b0, 8'h33);
        total++; if (rx_data_out !== 16'h1234) $display("FAIL busy_rx_hold got %h want 1234", rx_data_out); else passed++;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done_out) begin
                if (dn == 0) rx_at_done = rx_data_out;
                dn++;
            end
        end
        total++; if (dn !== 1) $display("FAIL busy_done_count got %0d want 1", dn); else passed++;
        total++; if (rx_at_done !== 16'hBEEF) $display("FAIL busy_rd_word got %h want beef", rx_at_done); else passed++;
        total++; if (busy_out !== 1'b0) $display("FAIL busy_idle got %b want 0", busy_out); else passed++;
    endtask

    task automatic test_abort;
        int dn = 0, n, ss_hi;
        bit hit = 0;
        slave_word = 16'h5A5A;
        start_xfer(1'b1, 8'h00);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if (rises == 5) begin
                hit = 1;
                break;
            end
        end
        total++; if (!hit) $display("FAIL abort_reach_bit5 got rises=%0d want 5", rises); else passed++;
        @(negedge clk) n_rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (SS_out !== 1'b1 || sclk_out !== 1'b0) $display("FAIL abort_lines got ss=%b sclk=%b want 1 0", SS_out, sclk_out); else passed++;
        total++; if (rx_data_out !== 16'h0) $display("FAIL abort_rx got %h want 0000", rx_data_out); else passed++;
        total++; if (busy_out !== 1'b0) $display("FAIL abort_busy got %b want 0", busy_out); else passed++;
        @(negedge clk) n_rst = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done_out) dn++;
        end
        total++; if (dn !== 0) $display("FAIL abort_no_done got %0d want 0", dn); else passed++;
        slave_word = 16'h0F0F;
        start_xfer(1'b1, 8'h00);
        wait_done(700, n, ss_hi);
        total++; if (n < 0 || rx_data_out !== 16'h0F0F) $display("FAIL abort_next_rd got %h n=%0d want 0f0f", rx_data_out, n); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int n, ss_hi;
        start_xfer(1'b0, 8'h01);
        wait_done(400, n, ss_hi);
        total++; if (n < 0 || last_byte !== 8'h01) $display("FAIL b2b_first got %h n=%0d want 01", last_byte, n); else passed++;
        @(posedge clk);
        #1;
        total++; if (SS_out !== 1'b1) $display("FAIL b2b_ss_gap got %b want 1", SS_out); else passed++;
        start_xfer(1'b0, 8'hFF);
        total++; if (SS_out !== 1'b0 || MOSI_out !== 1'b1) $display("FAIL b2b_restart got ss=%b mosi=%b want 0 1", SS_out, MOSI_out); else passed++;
        wait_done(400, n, ss_hi);
        total++; if (n + 1 !== 145 || last_byte !== 8'hFF) $display("FAIL b2b_second got %h n=%0d want ff at 144", last_byte, n); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rdy_wait;
`ifdef SPI_MASTER_RDY_WAIT_EN
        int n, ss_hi, bad = 0;
        slave_word = 16'hC3A1;
        data_ready_in = 1'b0;
        start_xfer(1'b1, 8'h00);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (SS_out !== 1'b1 || sclk_out !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL rdy_idle_lines got %0d bad cycles want 0", bad); else passed++;
        @(negedge clk) data_ready_in = 1'b1;
        wait_done(800, n, ss_hi);
        total++; if (n < 0 || rx_data_out !== 16'hC3A1) $display("FAIL rdy_word got %h n=%0d want c3a1", rx_data_out, n); else passed++;
        data_ready_in = 1'b0;
`else
        int n, ss_hi;
        slave_word = 16'hC3A1;
        data_ready_in = 1'b0;
        start_xfer(1'b1, 8'h00);
        total++; if (SS_out !== 1'b0) $display("FAIL nordy_ss got %b want 0", SS_out); else passed++;
        wait_done(700, n, ss_hi);
        total++; if (n + 1 !== 273 || rx_data_out !== 16'hC3A1) $display("FAIL nordy_word got %h n=%0d want c3a1 at 272", rx_data_out, n); else passed++;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_start_while_busy;
        test_abort;
        test_back_to_back;
        test_rdy_wait;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
